// File: rtl/logic_rmw_sequencer_pkg.sv
// Shared encodings for the logical-group sequencer: commands, FSM states, flag bit positions.
package logic_rmw_sequencer_pkg;

  localparam logic [2:0] CMD_ORA = 3'd0;
  localparam logic [2:0] CMD_AND = 3'd1;
  localparam logic [2:0] CMD_EOR = 3'd2;
  localparam logic [2:0] CMD_BIT = 3'd3;
  localparam logic [2:0] CMD_TSB = 3'd4;
  localparam logic [2:0] CMD_TRB = 3'd5;

  localparam int unsigned FLAG_N = 7;
  localparam int unsigned FLAG_V = 6;
  localparam int unsigned FLAG_Z = 1;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRead  = 3'd1,
    StExec  = 3'd2,
    StWrite = 3'd3,
    StDone  = 3'd4
  } state_e;

  function automatic logic cmd_legal(logic [2:0] cmd);
    return cmd <= CMD_TRB;
  endfunction

  function automatic logic cmd_is_rmw(logic [2:0] cmd);
    return (cmd == CMD_TSB) || (cmd == CMD_TRB);
  endfunction

  // Places per-flag enables at their status-register bit positions.
  function automatic logic [7:0] flag_we_mask(logic n, logic v, logic z);
    logic [7:0] mask;
    mask         = '0;
    mask[FLAG_N] = n;
    mask[FLAG_V] = v;
    mask[FLAG_Z] = z;
    return mask;
  endfunction

endpackage

// File: rtl/logic_rmw_sequencer_if.sv
// Decoder command, memory bus and register-file result signals of the sequencer.
interface logic_rmw_sequencer_if #(
  parameter int unsigned DBW = 16,
  parameter int unsigned ABW = 24
);
  logic           req_valid;
  logic           req_ready;
  logic [2:0]     req_cmd;
  logic           req_imm;
  logic [DBW-1:0] req_data;
  logic [ABW-1:0] req_addr;
  logic [DBW-1:0] acc_in;

  logic           mem_req;
  logic           mem_we;
  logic [ABW-1:0] mem_addr;
  logic [DBW-1:0] mem_wdata;
  logic [DBW-1:0] mem_rdata;
  logic           mem_ack;

  logic           done;
  logic [DBW-1:0] acc_out;
  logic           acc_we;
  logic           flag_n;
  logic           flag_z;
  logic           flag_v;
  logic           flag_n_we;
  logic           flag_z_we;
  logic           flag_v_we;

  modport slave (
    input  req_valid, req_cmd, req_imm, req_data, req_addr, acc_in, mem_rdata, mem_ack,
    output req_ready, mem_req, mem_we, mem_addr, mem_wdata,
    output done, acc_out, acc_we, flag_n, flag_z, flag_v, flag_n_we, flag_z_we, flag_v_we
  );

  modport master (
    output req_valid, req_cmd, req_imm, req_data, req_addr, acc_in, mem_rdata, mem_ack,
    input  req_ready, mem_req, mem_we, mem_addr, mem_wdata,
    input  done, acc_out, acc_we, flag_n, flag_z, flag_v, flag_n_we, flag_z_we, flag_v_we
  );
endinterface

// File: rtl/logic_rmw_sequencer_eval.sv
// Combinational logical-group datapath: result, write-back byte and raw N/Z/V values.
module logic_eval
  import logic_rmw_sequencer_pkg::*;
#(
  parameter int unsigned DBW = 16
) (
  input  logic [2:0]     cmd,
  input  logic [DBW-1:0] a,
  input  logic [DBW-1:0] m,
  output logic [DBW-1:0] r,
  output logic [DBW-1:0] w,
  output logic           n,
  output logic           z,
  output logic           v
);

  always_comb begin
    r = a & m;
    w = m;
    case (cmd)
      CMD_ORA: r = a | m;
      CMD_EOR: r = a ^ m;
      CMD_TSB: w = m | a;
      CMD_TRB: w = m & ~a;
      default: ;
    endcase
    n = (cmd == CMD_BIT) ? m[DBW-1] : r[DBW-1];
    // For BIT/TSB/TRB r already holds A&M, so one zero test serves every command.
    z = (r == '0);
    v = m[DBW-2];
  end

endmodule

// File: rtl/logic_rmw_sequencer.sv
// Multi-cycle sequencer for ORA/AND/EOR/BIT/TSB/TRB: operand fetch, evaluate, optional write-back.
module logic_rmw_sequencer
  import logic_rmw_sequencer_pkg::*;
#(
  parameter int unsigned DBW = 16,
  parameter int unsigned ABW = 24
) (
  input logic             clk,
  input logic             rst_n,
  logic_rmw_sequencer_if.slave bus
);

  state_e         state_q, state_d;
  logic [2:0]     cmd_q;
  logic [ABW-1:0] addr_q;
  logic [DBW-1:0] a_q;
  logic [DBW-1:0] m_q;
  logic           imm_q;

  logic [DBW-1:0] ev_r, ev_w;
  logic           ev_n, ev_z, ev_v;

  logic_eval #(.DBW(DBW)) u_eval (
    .cmd (cmd_q),
    .a   (a_q),
    .m   (m_q),
    .r   (ev_r),
    .w   (ev_w),
    .n   (ev_n),
    .z   (ev_z),
    .v   (ev_v)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cmd_q   <= '0;
      addr_q  <= '0;
      a_q     <= '0;
      m_q     <= '0;
      imm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && bus.req_valid) begin
        cmd_q  <= bus.req_cmd;
        addr_q <= bus.req_addr;
        a_q    <= bus.acc_in;
        imm_q  <= bus.req_imm;
        if (bus.req_imm) m_q <= bus.req_data;
      end else if (state_q == StRead && bus.mem_ack) begin
        m_q <= bus.mem_rdata;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    bus.req_ready = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.done      = 1'b0;
    bus.acc_we    = 1'b0;
    bus.flag_n_we = 1'b0;
    bus.flag_z_we = 1'b0;
    bus.flag_v_we = 1'b0;
    unique case (state_q)
      StIdle: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (!cmd_legal(bus.req_cmd)) state_d = StDone;
          else if (bus.req_imm)        state_d = StExec;
          else                         state_d = StRead;
        end
      end
      StRead: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = addr_q;
        if (bus.mem_ack) state_d = StExec;
      end
      StExec: begin
        state_d = (cmd_is_rmw(cmd_q) && !imm_q) ? StWrite : StDone;
      end
      StWrite: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = ev_w;
        if (bus.mem_ack) state_d = StDone;
      end
      StDone: begin
        bus.done = 1'b1;
        state_d  = StIdle;
        case (cmd_q)
          CMD_ORA, CMD_AND, CMD_EOR: begin
            bus.acc_we    = 1'b1;
            bus.flag_n_we = 1'b1;
            bus.flag_z_we = 1'b1;
          end
          CMD_BIT: begin
            // Immediate BIT only touches Z (65C02 behaviour).
            bus.flag_z_we = 1'b1;
            bus.flag_n_we = !imm_q;
            bus.flag_v_we = !imm_q;
          end
          CMD_TSB, CMD_TRB: bus.flag_z_we = 1'b1;
          default: ;
        endcase
      end
      default: state_d = StIdle;
    endcase
    bus.acc_out = bus.acc_we ? ev_r : '0;
    bus.flag_n  = bus.flag_n_we & ev_n;
    bus.flag_z  = bus.flag_z_we & ev_z;
    bus.flag_v  = bus.flag_v_we & ev_v;
  end

endmodule

// File: tb/tb_logic_rmw_sequencer.sv
// Scoreboard bench for logic_rmw_sequencer with a wait-state-programmable memory responder.
module tb_logic_rmw_sequencer;
  localparam int DBW = 16;
  localparam int ABW = 24;

  typedef struct packed {
    logic [15:0] acc;
    logic        acc_we, n, z, v, n_we, z_we, v_we;
  } res_t;

  typedef struct {
    res_t        res;
    int          lat;
    int          memc;
    bit          wr;
    logic [15:0] wdata;
    logic [23:0] addr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic_rmw_sequencer_if #(.DBW(DBW), .ABW(ABW)) bus ();

  logic_rmw_sequencer #(.DBW(DBW), .ABW(ABW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int          waits = 0;
  int          rsp_cnt = 0;
  int          wr_cnt = 0;
  logic [15:0] rd_value = '0;
  logic [15:0] wr_data = '0;
  logic [23:0] wr_addr = '0;

  // Memory responder: raises ack after `waits` stall cycles, logs completed writes.
  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n || !bus.mem_req) begin
        bus.mem_ack = 1'b0;
        rsp_cnt     = 0;
      end else begin
        rsp_cnt++;
        bus.mem_ack   = (rsp_cnt > waits);
        bus.mem_rdata = rd_value;
        if (bus.mem_ack && bus.mem_we) begin
          wr_cnt++;
          wr_data = bus.mem_wdata;
          wr_addr = bus.mem_addr;
        end
      end
    end
  end

  function automatic res_t model(logic [2:0] cmd, bit imm, logic [15:0] a, logic [15:0] m);
    res_t        e;
    logic [15:0] t;
    e = '0;
    t = '0;
    case (cmd)
      3'd0, 3'd1, 3'd2: begin
        if (cmd == 3'd0) t = a | m;
        else if (cmd == 3'd1) t = a & m;
        else t = a ^ m;
        e.acc = t; e.acc_we = 1'b1; e.n = t[15]; e.z = (t == 16'h0);
        e.n_we = 1'b1; e.z_we = 1'b1;
      end
      3'd3: begin
        e.z = ((a & m) == 16'h0); e.z_we = 1'b1;
        if (!imm) begin
          e.n = m[15]; e.v = m[14]; e.n_we = 1'b1; e.v_we = 1'b1;
        end
      end
      3'd4, 3'd5: begin
        e.z = ((a & m) == 16'h0); e.z_we = 1'b1;
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic push_exp(input res_t r, input int lat, input int memc, input bit wr,
                          input logic [15:0] wd, input logic [23:0] addr);
    exp_t e;
    e.res = r; e.lat = lat; e.memc = memc; e.wr = wr; e.wdata = wd; e.addr = addr;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [2:0] cmd, input bit imm, input logic [15:0] data,
                       input logic [23:0] addr, input logic [15:0] acc);
    @(negedge clk);
    bus.req_cmd   = cmd;
    bus.req_imm   = imm;
    bus.req_data  = data;
    bus.req_addr  = addr;
    bus.acc_in    = acc;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic await_done(output res_t obs, output int lat, output int memc, output bit ok);
    obs = '0; lat = 0; memc = 0; ok = 1'b0;
    for (int i = 1; i <= 200 && !ok; i++) begin
      @(negedge clk);
      if (bus.mem_req) memc++;
      if (bus.done) begin
        ok = 1'b1;
        lat = i;
        obs.acc    = bus.acc_we ? bus.acc_out : 16'h0;
        obs.acc_we = bus.acc_we;
        obs.n      = bus.flag_n & bus.flag_n_we;
        obs.z      = bus.flag_z & bus.flag_z_we;
        obs.v      = bus.flag_v & bus.flag_v_we;
        obs.n_we   = bus.flag_n_we;
        obs.z_we   = bus.flag_z_we;
        obs.v_we   = bus.flag_v_we;
      end
    end
  endtask

  task automatic test_reset();
    logic [6:0] got;
    bus.req_valid = 1'b1; bus.req_cmd = 3'd0; bus.req_imm = 1'b1;
    bus.req_data = 16'hFFFF; bus.req_addr = '0; bus.acc_in = 16'hFFFF;
    repeat (3) @(negedge clk);
    got = {bus.req_ready, bus.mem_req, bus.done, bus.acc_we,
           bus.flag_n_we, bus.flag_z_we, bus.flag_v_we};
    tests += 2;
    if (got !== 7'b1000000) begin
      fails++; $display("FAIL reset_outputs: got %b want 1000000", got);
    end
    if (bus.acc_out !== 16'h0 || bus.mem_addr !== 24'h0) begin
      fails++; $display("FAIL reset_data: acc_out %h mem_addr %h want 0", bus.acc_out, bus.mem_addr);
    end
    bus.req_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_ora_imm();
    res_t obs; int lat, memc; bit ok; exp_t e;
    waits = 0;
    push_exp('{acc: 16'hFF0F, acc_we: 1, n: 1, z: 0, v: 0, n_we: 1, z_we: 1, v_we: 0},
             2, 0, 0, 16'h0, 24'h0);
    issue(3'd0, 1'b1, 16'hF000, 24'h000010, 16'h0F0F);
    await_done(obs, lat, memc, ok);
    e = sb.pop_front();
    tests += 2;
    if (!ok || obs !== e.res) begin
      fails++; $display("FAIL ora_imm_result: got %h want %h (done=%0d)", obs, e.res, ok);
    end
    if (lat !== e.lat || memc !== e.memc) begin
      fails++; $display("FAIL ora_imm_timing: lat %0d memc %0d want %0d %0d", lat, memc, e.lat, e.memc);
    end
  endtask

  task automatic test_and_wait();
    res_t obs; int lat, memc, extra; bit ok; exp_t e;
    waits = 3; rd_value = 16'hFF00;
    push_exp('{acc: 16'h0000, acc_we: 1, n: 0, z: 1, v: 0, n_we: 1, z_we: 1, v_we: 0},
             6, 4, 0, 16'h0, 24'h000200);
    issue(3'd1, 1'b0, 16'h0, 24'h000200, 16'h00FF);
    // A second command held on req_valid while busy must be dropped, not queued.
    bus.req_valid = 1'b1; bus.req_cmd = 3'd0; bus.req_imm = 1'b1; bus.req_data = 16'hFFFF;
    await_done(obs, lat, memc, ok);
    bus.req_valid = 1'b0;
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.done) extra++;
    end
    e = sb.pop_front();
    tests += 3;
    if (!ok || obs !== e.res) begin
      fails++; $display("FAIL and_wait_result: got %h want %h (done=%0d)", obs, e.res, ok);
    end
    if (lat !== e.lat || memc !== e.memc) begin
      fails++; $display("FAIL and_wait_timing: lat %0d memc %0d want %0d %0d", lat, memc, e.lat, e.memc);
    end
    if (extra !== 0 || bus.req_ready !== 1'b1) begin
      fails++; $display("FAIL busy_req_ignored: extra done %0d ready %b want 0 1", extra, bus.req_ready);
    end
  endtask

  task automatic test_bit_mem();
    res_t obs; int lat, memc; bit ok; exp_t e;
    waits = 0; rd_value = 16'hC000;
    push_exp('{acc: 16'h0, acc_we: 0, n: 1, z: 1, v: 1, n_we: 1, z_we: 1, v_we: 1},
             3, 1, 0, 16'h0, 24'h000300);
    issue(3'd3, 1'b0, 16'h0, 24'h000300, 16'h0001);
    await_done(obs, lat, memc, ok);
    e = sb.pop_front();
    tests += 2;
    if (!ok || obs !== e.res) begin
      fails++; $display("FAIL bit_mem_result: got %h want %h (done=%0d)", obs, e.res, ok);
    end
    if (lat !== e.lat || memc !== e.memc) begin
      fails++; $display("FAIL bit_mem_timing: lat %0d memc %0d want %0d %0d", lat, memc, e.lat, e.memc);
    end
  endtask

  task automatic test_tsb_mem();
    res_t obs; int lat, memc, w0; bit ok; exp_t e;
    waits = 0; rd_value = 16'h0100; w0 = wr_cnt;
    push_exp('{acc: 16'h0, acc_we: 0, n: 0, z: 1, v: 0, n_we: 0, z_we: 1, v_we: 0},
             4, 2, 1, 16'h0111, 24'hABCDEF);
    issue(3'd4, 1'b0, 16'h0, 24'hABCDEF, 16'h0011);
    await_done(obs, lat, memc, ok);
    e = sb.pop_front();
    tests += 3;
    if (!ok || obs !== e.res) begin
      fails++; $display("FAIL tsb_mem_result: got %h want %h (done=%0d)", obs, e.res, ok);
    end
    if (lat !== e.lat || memc !== e.memc) begin
      fails++; $display("FAIL tsb_mem_timing: lat %0d memc %0d want %0d %0d", lat, memc, e.lat, e.memc);
    end
    if (wr_cnt - w0 !== 1 || wr_data !== e.wdata || wr_addr !== e.addr) begin
      fails++; $display("FAIL tsb_mem_write: n %0d data %h addr %h want 1 %h %h",
                        wr_cnt - w0, wr_data, wr_addr, e.wdata, e.addr);
    end
  endtask

  task automatic test_special();
    logic [2:0]  cmds[3] = '{3'd6, 3'd3, 3'd5};
    logic [15:0] accs[3] = '{16'hFFFF, 16'hFFFF, 16'h00FF};
    logic [15:0] dats[3] = '{16'hFFFF, 16'h8000, 16'h0F00};
    bit          imms[3] = '{1'b0, 1'b1, 1'b1};
    res_t exps[3] = '{
      '{acc: 16'h0, acc_we: 0, n: 0, z: 0, v: 0, n_we: 0, z_we: 0, v_we: 0},
      '{acc: 16'h0, acc_we: 0, n: 0, z: 0, v: 0, n_we: 0, z_we: 1, v_we: 0},
      '{acc: 16'h0, acc_we: 0, n: 0, z: 1, v: 0, n_we: 0, z_we: 1, v_we: 0}};
    int   lats[3] = '{1, 2, 2};
    res_t obs; int lat, memc, w0; bit ok; exp_t e;
    waits = 0; rd_value = 16'h5555;
    for (int k = 0; k < 3; k++) begin
      w0 = wr_cnt;
      push_exp(exps[k], lats[k], 0, 0, 16'h0, 24'h0);
      issue(cmds[k], imms[k], dats[k], 24'h000400, accs[k]);
      await_done(obs, lat, memc, ok);
      e = sb.pop_front();
      tests += 2;
      if (!ok || obs !== e.res) begin
        fails++; $display("FAIL special%0d_result: got %h want %h (done=%0d)", k, obs, e.res, ok);
      end
      if (lat !== e.lat || memc !== 0 || wr_cnt !== w0) begin
        fails++; $display("FAIL special%0d_timing: lat %0d memc %0d writes %0d want %0d 0 0",
                          k, lat, memc, wr_cnt - w0, e.lat);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    res_t obs; int lat, memc, w0, dn; bit ok, found; exp_t e;
    waits = 4; rd_value = 16'h00F0; w0 = wr_cnt; found = 1'b0;
    issue(3'd4, 1'b0, 16'h0, 24'h123456, 16'h0F00);
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (bus.mem_req && bus.mem_we) found = 1'b1;
    end
    #2 rst_n = 1'b0;
    #1;
    tests += 3;
    if (!found || bus.mem_req !== 1'b0 || bus.req_ready !== 1'b1) begin
      fails++; $display("FAIL reset_mid_write: found %b mem_req %b ready %b want 1 0 1",
                        found, bus.mem_req, bus.req_ready);
    end
    dn = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done) dn++;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (bus.done) dn++;
    end
    if (dn !== 0 || wr_cnt !== w0 || bus.req_ready !== 1'b1) begin
      fails++; $display("FAIL reset_abandon: done %0d writes %0d ready %b want 0 0 1",
                        dn, wr_cnt - w0, bus.req_ready);
    end
    waits = 0;
    push_exp('{acc: 16'hFF00, acc_we: 1, n: 1, z: 0, v: 0, n_we: 1, z_we: 1, v_we: 0},
             2, 0, 0, 16'h0, 24'h0);
    issue(3'd2, 1'b1, 16'h00FF, 24'h0, 16'hFFFF);
    await_done(obs, lat, memc, ok);
    e = sb.pop_front();
    if (!ok || obs !== e.res || lat !== e.lat) begin
      fails++; $display("FAIL after_reset_eor: got %h lat %0d want %h lat %0d", obs, lat, e.res, e.lat);
    end
  endtask

  task automatic test_back_to_back();
    res_t obs; int lat, memc, w0; bit ok; exp_t e;
    logic [2:0] cmd; bit imm, rmw, legal; logic [15:0] a, d, m; logic [23:0] addr;
    for (int k = 0; k < 24; k++) begin
      cmd = 3'($urandom_range(0, 7)); imm = 1'($urandom_range(0, 1));
      a = 16'($urandom); d = 16'($urandom); addr = 24'($urandom);
      waits = $urandom_range(0, 2); rd_value = 16'($urandom);
      m = imm ? d : rd_value;
      legal = (cmd <= 3'd5); rmw = legal && (cmd >= 3'd4) && !imm;
      w0 = wr_cnt;
      push_exp(model(cmd, imm, a, m),
               !legal ? 1 : 2 + (imm ? 0 : 1 + waits) + (rmw ? 1 + waits : 0),
               (!legal || imm) ? 0 : (1 + waits) * (rmw ? 2 : 1),
               rmw, (cmd == 3'd4) ? (m | a) : (m & ~a), addr);
      issue(cmd, imm, d, addr, a);
      await_done(obs, lat, memc, ok);
      e = sb.pop_front();
      tests += 2;
      if (!ok || obs !== e.res || lat !== e.lat || memc !== e.memc) begin
        fails++; $display("FAIL b2b%0d cmd%0d imm%0d: got %h lat %0d memc %0d want %h %0d %0d",
                          k, cmd, imm, obs, lat, memc, e.res, e.lat, e.memc);
      end
      if ((wr_cnt - w0) !== int'(e.wr) || (e.wr && (wr_data !== e.wdata || wr_addr !== e.addr))) begin
        fails++; $display("FAIL b2b%0d_write: n %0d data %h addr %h want %0d %h %h",
                          k, wr_cnt - w0, wr_data, wr_addr, e.wr, e.wdata, e.addr);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0; bus.req_cmd = '0; bus.req_imm = 1'b0;
    bus.req_data = '0; bus.req_addr = '0; bus.acc_in = '0;
    test_reset();
    test_ora_imm();
    test_and_wait();
    test_bit_mem();
    test_tsb_mem();
    test_special();
    test_reset_mid_write();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
